load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have one clock `clk`, and `reset` SHALL be asynchronous and active-low.
REQ-002 Parameter: ADDR_W, default 32, byte-address width.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  asynchronous, active-low; low forces reset state immediately.
REQ-005 mem_req  in  1  core requests a load or store; held high until stall deasserts.
REQ-006 mem_we  in  1  1 = store, 0 = load; valid with mem_req.
REQ-007 funct3  in  3  RV32I width/sign code: LB 000, LH 001, LW 010, LBU 100, LHU 101, SB 000, SH 001, SW 010.
REQ-008 addr  in  ADDR_W  byte address (ALU result).
REQ-009 wdata  in  32  store data (rs2 value).
REQ-010 rdata  out  32  aligned, extended load result (datapath memory read data).
REQ-011 stall  out  1  core shall hold PC and register write-back while high.
REQ-012 misaligned  out  1  one-cycle pulse when an access is rejected for misalignment.
REQ-013 bus_valid  out  1  bus request valid.
REQ-014 bus_ready  in  1  bus accepts request when high with bus_valid.
REQ-015 bus_we  out  1  bus write.
REQ-016 bus_addr  out  ADDR_W  word-aligned address; bits [1:0] = 00.
REQ-017 bus_be  out  4  byte enables.
REQ-018 bus_wdata  out  32  lane-replicated store data.
REQ-019 bus_rdata  in  32  read word, valid with bus_rvalid.
REQ-020 bus_rvalid  in  1  read data valid; sampled only in WAIT_R.

Function
REQ-021 FSM states SHALL be IDLE, REQ, WAIT_R, and DONE.
REQ-022 IDLE: on mem_req with an aligned address, latch mem_we/funct3/addr/wdata and go to REQ; stall=1 combinationally in that cycle.
REQ-023 Alignment: halfword requires addr[0]=0; word requires addr[1:0]=00; byte is always aligned.
REQ-024 Misaligned request in IDLE: misaligned=1 and stall=0 for that cycle, no bus transaction, rdata=0, remain in IDLE.
REQ-025 REQ: bus_valid=1 and stall=1; bus outputs stable until bus_ready. On bus_ready, a store goes to DONE and a load goes to WAIT_R.
REQ-026 WAIT_R: stall=1; on bus_rvalid, register the extracted/extended data into rdata and go to DONE.
REQ-027 DONE: stall=0 for exactly one cycle; mem_req is ignored; then go to IDLE. Back-to-back requests are accepted in the following IDLE cycle.
REQ-028 Minimum stall: store 2 cycles (IDLE+REQ); load 3 cycles (IDLE+REQ+WAIT_R, with rvalid one cycle after handshake).
REQ-029 Store lanes: SB be=0001<<addr[1:0], wdata byte replicated 4x; SH be=0011<<addr[1:0], halfword replicated 2x; SW be=1111.
REQ-030 Load be: same pattern as stores.
REQ-031 Load extraction: shift bus_rdata right by 8*addr[1:0]; LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
REQ-032 rdata SHALL hold its value until the next load completes; stores do not alter it.
REQ-033 Outside REQ: bus_valid=0, bus_we=0, and bus_be=0000.
REQ-034 Unknown funct3 values (011, 110, 111) SHALL be treated as word width.

Reset
REQ-035 reset low SHALL force state=IDLE, rdata=0, and all latched fields to 0, with no clock required.
REQ-036 While reset is low, all outputs SHALL be 0.
REQ-037 Reset mid-transaction SHALL abandon the access, drop bus_valid immediately, and ignore a subsequent bus_rvalid.

Structure
REQ-038 The FSM state enum and funct3 width constants SHALL live in the shared package alongside instr_type_enum.
REQ-039 Lane/byte-enable generation and load extraction/extension SHALL be a combinational sub-module `lsu_align`.

Verification
REQ-040 SW: addr=0x100, wdata=0xDEADBEEF, bus_ready on first REQ cycle -> bus_addr=0x100, be=1111, stall high 2 cycles.
REQ-041 LB: addr=0x103, bus_rdata=0x80FF1234, rvalid after 2 wait cycles -> rdata=0xFFFFFF80, stall high 5 cycles.
REQ-042 LHU: addr=0x202, bus_rdata=0xBEEF0000 -> rdata=0x0000BEEF, be=1100, bus_addr=0x200.
REQ-043 SB: addr=0x101, wdata=0x000000AB -> be=0010, bus_wdata=0xABABABAB.
REQ-044 LW: addr=0x102 -> misaligned pulse, no bus_valid, stall=0.
REQ-045 Reset low during WAIT_R, then release -> state IDLE, bus_valid=0, rdata=0, late rvalid ignored.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: FSM state codes, funct3 width codes,
// instruction type and the width/alignment helpers used by the LSU datapath.
package load_store_unit_pkg;

  typedef logic [1:0] lsu_state_t;

  localparam lsu_state_t ST_IDLE   = 2'd0;
  localparam lsu_state_t ST_REQ    = 2'd1;
  localparam lsu_state_t ST_WAIT_R = 2'd2;
  localparam lsu_state_t ST_DONE   = 2'd3;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    INSTR_LOAD  = 2'd0,
    INSTR_STORE = 2'd1,
    INSTR_OTHER = 2'd2
  } instr_type_enum;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } mem_size_e;

  // Reserved funct3 codes fall through to word width.
  function automatic mem_size_e decode_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SIZE_B;
      F3_H, F3_HU: return SIZE_H;
      default:     return SIZE_W;
    endcase
  endfunction

  function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] lo);
    case (decode_size(f3))
      SIZE_B:  return 1'b1;
      SIZE_H:  return ~lo[0];
      default: return (lo == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Byte-lane steering for the LSU: byte enables, store-data replication and
// load-data extraction with sign/zero extension.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  be,
  output logic [31:0] lane_wdata,
  output logic [31:0] load_data
);

  mem_size_e   size_s;
  logic [31:0] shifted_s;

  assign size_s    = decode_size(funct3);
  assign shifted_s = bus_rdata >> {offset, 3'b000};

  // Per-width lane selection; funct3[2] marks the unsigned load variants.
  always_comb begin
    be         = 4'b0000;
    lane_wdata = 32'h0000_0000;
    load_data  = 32'h0000_0000;
    case (size_s)
      SIZE_B: begin
        be         = 4'b0001 << offset;
        lane_wdata = {4{wdata[7:0]}};
        if (funct3[2]) begin
          load_data = {24'h00_0000, shifted_s[7:0]};
        end else begin
          load_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
        end
      end
      SIZE_H: begin
        be         = 4'b0011 << offset;
        lane_wdata = {2{wdata[15:0]}};
        if (funct3[2]) begin
          load_data = {16'h0000, shifted_s[15:0]};
        end else begin
          load_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
        end
      end
      default: begin
        be         = 4'b1111;
        lane_wdata = wdata;
        load_data  = shifted_s;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: accepts one aligned access from the core, runs a single
// bus transaction and returns the extended load result, stalling the core meanwhile.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              misaligned,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_rvalid
);

  lsu_state_t        state_r;
  instr_type_enum    op_r;
  logic [2:0]        funct3_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;
  logic [31:0]       rdata_r;

  logic              req_aligned_s;
  logic [3:0]        be_s;
  logic [31:0]       lane_wdata_s;
  logic [31:0]       load_data_s;

  assign req_aligned_s = is_aligned(funct3, addr[1:0]);

  lsu_align u_align (
    .funct3     (funct3_r),
    .offset     (addr_r[1:0]),
    .wdata      (wdata_r),
    .bus_rdata  (bus_rdata),
    .be         (be_s),
    .lane_wdata (lane_wdata_s),
    .load_data  (load_data_s)
  );

  // Transaction FSM and request capture; rdata_r only changes when a load finishes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      op_r     <= INSTR_LOAD;
      funct3_r <= 3'b000;
      addr_r   <= {ADDR_W{1'b0}};
      wdata_r  <= 32'h0000_0000;
      rdata_r  <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (mem_req && req_aligned_s) begin
            state_r  <= ST_REQ;
            op_r     <= mem_we ? INSTR_STORE : INSTR_LOAD;
            funct3_r <= funct3;
            addr_r   <= addr;
            wdata_r  <= wdata;
          end
        end
        ST_REQ: begin
          if (bus_ready) begin
            state_r <= (op_r == INSTR_STORE) ? ST_DONE : ST_WAIT_R;
          end
        end
        ST_WAIT_R: begin
          if (bus_rvalid) begin
            rdata_r <= load_data_s;
            state_r <= ST_DONE;
          end
        end
        ST_DONE: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Core/bus handshake outputs; everything is forced low while reset is held.
  always_comb begin
    stall      = 1'b0;
    misaligned = 1'b0;
    bus_valid  = 1'b0;
    if (!reset) begin
      stall      = 1'b0;
      misaligned = 1'b0;
      bus_valid  = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (mem_req) begin
            stall      = req_aligned_s;
            misaligned = ~req_aligned_s;
          end else begin
            stall      = 1'b0;
            misaligned = 1'b0;
          end
        end
        ST_REQ: begin
          stall     = 1'b1;
          bus_valid = 1'b1;
        end
        ST_WAIT_R: stall = 1'b1;
        ST_DONE:   stall = 1'b0;
        default:   stall = 1'b0;
      endcase
    end
    bus_we    = bus_valid && (op_r == INSTR_STORE);
    bus_be    = bus_valid ? be_s : 4'b0000;
    bus_addr  = {addr_r[ADDR_W-1:2], 2'b00};
    bus_wdata = lane_wdata_s;
    rdata     = misaligned ? 32'h0000_0000 : rdata_r;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a byte-level memory model predicts bus
// requests and load results; a bus responder and a core-side monitor compare them.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req, mem_we;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, rdata;
  logic        stall, misaligned;
  logic        bus_valid, bus_ready, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        bus_rvalid;

  int checks = 0;
  int errors = 0;

  typedef struct {bit mis; bit is_load; logic [31:0] rd; int stall_cyc;} done_t;
  typedef struct {bit we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata;} bus_t;
  typedef struct {int rdy; int vld;} dly_t;

  done_t done_q[$];
  bus_t  bus_q[$];
  dly_t  dly_q[$];

  logic [7:0]  shadow [0:1023];
  logic [31:0] bus_mem [0:255];
  logic [31:0] last_load = 32'h0;
  bit          mon_en = 1'b0;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .funct3(funct3),
    .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .misaligned(misaligned),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  // Reference model: byte-addressed memory, little-endian, RV32I extension rules.
  task automatic expect_txn(input bit we, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input int rd, input int vd, input bit track);
    int n;
    done_t d;
    bus_t b;
    dly_t dl;
    logic [31:0] v, m;
    n = nbytes(f3);
    d.mis = (int'(a[1:0]) % n) != 0;
    d.is_load = !we;
    d.rd = 32'h0;
    d.stall_cyc = 0;
    if (!d.mis) begin
      b.we = we;
      b.addr = {a[31:2], 2'b00};
      b.be = 4'h0;
      b.wdata = 32'h0;
      for (int i = 0; i < n; i++) b.be[(int'(a[1:0]) + i) % 4] = 1'b1;
      if (we) begin
        for (int k = 0; k < 4; k++) b.wdata[8*k +: 8] = wd[8*(k % n) +: 8];
        for (int i = 0; i < n; i++) shadow[int'(a) + i] = wd[8*i +: 8];
        d.rd = last_load;
        d.stall_cyc = 2 + rd;
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | ({24'h0, shadow[int'(a) + i]} << (8*i));
        if (n < 4 && !f3[2] && v[8*n-1]) begin
          m = (32'h1 << (8*n)) - 32'h1;
          v = v | ~m;
        end
        last_load = v;
        d.rd = v;
        d.stall_cyc = 3 + rd + vd;
      end
      dl.rdy = rd;
      dl.vld = vd;
      bus_q.push_back(b);
      dly_q.push_back(dl);
    end
    if (track) done_q.push_back(d);
  endtask

  task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int rd, input int vd);
    int t;
    expect_txn(we, f3, a, wd, rd, vd, 1'b1);
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = we; funct3 = f3; addr = a; wdata = wd;
    t = 0;
    @(negedge clk);
    while (stall && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (stall) begin
      checks++;
      errors++;
      $display("FAIL completion_timeout: stall still 1 after %0d cycles, required 0", t);
    end
  endtask

  task automatic gap(input int n);
    @(posedge clk); #1;
    mem_req = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  // Bus responder: checks each request against the model and serves it with chosen delays.
  initial begin
    bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (bus_valid) begin
        dly_t dl;
        bus_t e;
        logic [31:0] a0;
        logic [3:0] be0;
        logic rd_op;
        logic [7:0] widx;
        dl = (dly_q.size() != 0) ? dly_q.pop_front() : '{0, 0};
        a0 = bus_addr;
        be0 = bus_be;
        for (int i = 0; i < dl.rdy; i++) begin
          @(negedge clk);
          chk("bus_hold_valid", 32'(bus_valid), 32'h1);
          chk("bus_hold_addr", bus_addr, a0);
          chk("bus_hold_be", 32'(bus_be), 32'(be0));
        end
        bus_ready = 1'b1;
        if (bus_q.size() != 0) begin
          e = bus_q.pop_front();
          chk("bus_we", 32'(bus_we), 32'(e.we));
          chk("bus_addr", bus_addr, e.addr);
          chk("bus_be", 32'(bus_be), 32'(e.be));
          if (e.we) chk("bus_wdata", bus_wdata, e.wdata);
        end else begin
          checks++;
          errors++;
          $display("FAIL bus_unexpected: got request addr %h, required none", bus_addr);
        end
        widx = bus_addr[9:2];
        rd_op = !bus_we;
        if (bus_we) begin
          for (int k = 0; k < 4; k++)
            if (bus_be[k]) bus_mem[widx][8*k +: 8] = bus_wdata[8*k +: 8];
        end
        @(negedge clk);
        bus_ready = 1'b0;
        if (rd_op) begin
          repeat (dl.vld) @(negedge clk);
          bus_rdata = bus_mem[widx];
          bus_rvalid = 1'b1;
          @(negedge clk);
          bus_rvalid = 1'b0;
        end
      end
    end
  end

  // Core-side monitor: counts stall cycles and scores each completed access.
  initial begin
    int cnt;
    done_t d;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        cnt = 0;
      end else begin
        if (!bus_valid) chk("idle_bus_we_be", {27'h0, bus_we, bus_be}, 32'h0);
        if (stall) cnt++;
        if (mem_req && !stall) begin
          if (done_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL done_unexpected: got completion, required none");
          end else begin
            d = done_q.pop_front();
            chk("misaligned", 32'(misaligned), 32'(d.mis));
            if (d.mis) begin
              chk("mis_rdata", rdata, 32'h0);
              chk("mis_bus_valid", 32'(bus_valid), 32'h0);
              chk("mis_stall_cycles", 32'(cnt), 32'h0);
            end else begin
              chk(d.is_load ? "load_rdata" : "store_keeps_rdata", rdata, d.rd);
              chk("stall_cycles", 32'(cnt), 32'(d.stall_cyc));
            end
          end
          cnt = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] ld_f3 [8];
    logic [2:0] st_f3 [4];
    ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
    st_f3 = '{3'b000, 3'b001, 3'b010, 3'b011};
    for (int w = 0; w < 256; w++) bus_mem[w] = $urandom;
    bus_mem[64]  = 32'h80FF_1234;
    bus_mem[128] = 32'hBEEF_0000;
    for (int w = 0; w < 256; w++)
      for (int k = 0; k < 4; k++) shadow[4*w + k] = bus_mem[w][8*k +: 8];

    reset = 1'b0; mem_req = 1'b1; mem_we = 1'b0; funct3 = 3'b010; addr = 32'h0; wdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_misaligned", 32'(misaligned), 32'h0);
    chk("rst_bus_valid", 32'(bus_valid), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_bus_fields", bus_addr | bus_wdata | 32'(bus_be) | 32'(bus_we), 32'h0);
    mem_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    mon_en = 1'b1;

    issue(1'b0, 3'b000, 32'h103, 32'h0, 0, 2);
    issue(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 0, 0);
    issue(1'b1, 3'b000, 32'h101, 32'h0000_00AB, 0, 0);
    issue(1'b0, 3'b101, 32'h202, 32'h0, 0, 0);
    issue(1'b0, 3'b010, 32'h102, 32'h0, 0, 0);
    issue(1'b1, 3'b001, 32'h103, 32'h1234_5678, 0, 0);
    issue(1'b0, 3'b010, 32'h100, 32'h0, 1, 1);
    issue(1'b0, 3'b001, 32'h102, 32'h0, 0, 0);
    gap(2);

    for (int t = 0; t < 150; t++) begin
      bit we;
      logic [2:0] f3;
      we = 1'($urandom_range(0, 1));
      f3 = we ? st_f3[$urandom_range(0, 3)] : ld_f3[$urandom_range(0, 7)];
      issue(we, f3, 32'($urandom_range(0, 1023)), $urandom,
            $urandom_range(0, 3), $urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) gap($urandom_range(1, 3));
    end
    gap(2);

    // Reset in WAIT_R: the access is abandoned and the late rvalid must be ignored.
    mon_en = 1'b0;
    expect_txn(1'b0, 3'b010, 32'h40, 32'h0, 0, 8, 1'b0);
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = 1'b0; funct3 = 3'b010; addr = 32'h40;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_bus_valid", 32'(bus_valid), 32'h0);
    chk("mid_rst_stall", 32'(stall), 32'h0);
    chk("mid_rst_rdata", rdata, 32'h0);
    chk("mid_rst_bus_fields", bus_addr | bus_wdata | 32'(bus_be) | 32'(bus_we), 32'h0);
    mem_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    last_load = 32'h0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_rst_bus_valid", 32'(bus_valid), 32'h0);
      chk("post_rst_rdata", rdata, 32'h0);
    end
    mon_en = 1'b1;
    issue(1'b1, 3'b000, 32'h12, 32'h0000_0055, 0, 0);
    issue(1'b0, 3'b100, 32'h12, 32'h0, 0, 0);
    gap(4);

    chk("done_q_empty", 32'(done_q.size()), 32'h0);
    chk("bus_q_empty", 32'(bus_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
